nonce_dispatch_scheduler: RTL and testbench

- Sequences a bank of NUM_CORES Voodoo mining cores for one work unit.
- Splits the 32-bit nonce space into equal contiguous sub-ranges, one per core.
- Clears, launches and monitors the cores, and reports job completion.
- Collects per-core found-nonce pulses into pending slots and drains them to the host interface through a round-robin arbiter with a valid/ready handshake.

---
 rtl/nonce_dispatch_scheduler_if.sv | 34 +++
 rtl/nonce_dispatch_scheduler.sv | 139 +++++++++++++
 tb/tb_nonce_dispatch_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nonce_dispatch_scheduler_if.sv
// Host-side found-nonce channel of nonce_dispatch_scheduler.
// The scheduler drives it through the master modport, the host consumes it
// through the slave modport. When FOUND_CORE_ID_EN is defined the channel
// also carries the index of the core that found the presented nonce.
interface nonce_dispatch_scheduler_if
`ifdef FOUND_CORE_ID_EN
  #(parameter int IDX_W = 2)
`endif
  ;
  logic        found_valid;
  logic [31:0] found_nonce;
  logic        found_ready;
`ifdef FOUND_CORE_ID_EN
  logic [IDX_W-1:0] found_core;
`endif

  modport master (
    output found_valid,
    output found_nonce,
`ifdef FOUND_CORE_ID_EN
    output found_core,
`endif
    input  found_ready
  );

  modport slave (
    input  found_valid,
    input  found_nonce,
`ifdef FOUND_CORE_ID_EN
    input  found_core,
`endif
    output found_ready
  );
endinterface

// File: rtl/nonce_dispatch_scheduler.sv
// nonce_dispatch_scheduler: sequences a bank of mining cores over one work
// unit. Each core gets a fixed contiguous slice of the 32-bit nonce space;
// the job FSM clears, launches and monitors the cores, and found nonces are
// parked in per-core slots and drained to the host by a round-robin arbiter.
// Optional feature macro: FOUND_CORE_ID_EN adds host.found_core.
module nonce_dispatch_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int LOG2_CORES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    work_valid,
  output logic                    busy,
  output logic                    job_done,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [32*NUM_CORES-1:0] core_nonce_start,
  output logic [32*NUM_CORES-1:0] core_nonce_end,
  input  logic [NUM_CORES-1:0]    core_busy,
  input  logic [NUM_CORES-1:0]    core_found,
  input  logic [32*NUM_CORES-1:0] core_nonce,
  nonce_dispatch_scheduler_if.master host,
  output logic                    overflow
);

  localparam int          IDX_W     = (LOG2_CORES > 0) ? LOG2_CORES : 1;
  localparam logic [31:0] SPAN_MASK = 32'hFFFF_FFFF >> LOG2_CORES;

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [NUM_CORES-1:0] pending_reg, pending_next;
  logic [NUM_CORES-1:0] clear_slot, ovf_hit;
  logic [31:0]        slot_reg [NUM_CORES];
  logic               valid_reg;
  logic [31:0]        nonce_reg;
  logic [IDX_W-1:0]   grant_reg, ptr_reg, grant_idx, ptr_after;
  logic               grant_any, handshake, overflow_reg;

  // Static range split: the top LOG2_CORES bits select the core, the rest span the slice.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_range
      localparam logic [31:0] BASE = (LOG2_CORES > 0) ? (32'(gi) << (32 - LOG2_CORES)) : 32'h0;
      assign core_nonce_start[32*gi +: 32] = BASE;
      assign core_nonce_end[32*gi +: 32]   = BASE | SPAN_MASK;
    end
  endgenerate

  // Job FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Job FSM next state and decoded outputs; a new work unit always restarts via CLEAR.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    job_done   = 1'b0;
    core_reset = 1'b0;
    core_start = 1'b0;
    case (state_reg)
      IDLE:      ;
      CLEAR:     begin busy = 1'b1; core_reset = 1'b1; state_next = LAUNCH; end
      LAUNCH:    begin busy = 1'b1; core_start = 1'b1; state_next = WAIT_BUSY; end
      WAIT_BUSY: begin busy = 1'b1; if (&core_busy) state_next = RUN; end
      RUN:       begin busy = 1'b1; if (~|core_busy) state_next = DONE; end
      DONE:      begin busy = 1'b1; job_done = 1'b1; state_next = IDLE; end
      default:   state_next = IDLE;
    endcase
    if (work_valid) state_next = CLEAR;
  end

  assign handshake = valid_reg & host.found_ready;

  // Per-slot capture: a fresh find beats a same-cycle drain and is not an overflow.
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_slot
      assign clear_slot[gi]   = handshake & (grant_reg == IDX_W'(gi));
      assign pending_next[gi] = core_found[gi] | (pending_reg[gi] & ~clear_slot[gi]);
      assign ovf_hit[gi]      = core_found[gi] & pending_reg[gi] & ~clear_slot[gi];
    end
  endgenerate

  // Slot storage, pending flags and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) slot_reg[i] <= '0;
    end else begin
      pending_reg  <= pending_next;
      overflow_reg <= overflow_reg | (|ovf_hit);
      for (int i = 0; i < NUM_CORES; i++)
        if (core_found[i]) slot_reg[i] <= core_nonce[32*i +: 32];
    end
  end

  // Round-robin pick: first pending slot at or above the pointer, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr_reg) + k) % NUM_CORES;
      if (pending_reg[j]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    ptr_after = (grant_reg == IDX_W'(NUM_CORES - 1)) ? '0 : grant_reg + 1'b1;
  end

  // Presentation register: load on grant, hold until accepted, then advance the pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= 1'b0;
      nonce_reg <= '0;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else if (handshake) begin
      valid_reg <= 1'b0;
      ptr_reg   <= ptr_after;
    end else if (!valid_reg && grant_any) begin
      valid_reg <= 1'b1;
      nonce_reg <= slot_reg[grant_idx];
      grant_reg <= grant_idx;
    end
  end

  assign host.found_valid = valid_reg;
  assign host.found_nonce = nonce_reg;
`ifdef FOUND_CORE_ID_EN
  assign host.found_core  = grant_reg;
`endif
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_nonce_dispatch_scheduler.sv
// Bench for nonce_dispatch_scheduler (NUM_CORES=4): directed scenarios with
// literal expectations, then randomized traffic, all also checked every cycle
// against a job/slot-level reference model.
module tb_nonce_dispatch_scheduler;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           work_valid = 1'b0;
  logic           busy, job_done, core_reset, core_start, overflow;
  logic [32*N-1:0] core_nonce_start, core_nonce_end;
  logic [N-1:0]   core_busy = '0;
  logic [N-1:0]   core_found = '0;
  logic [32*N-1:0] core_nonce = '0;

`ifdef FOUND_CORE_ID_EN
  nonce_dispatch_scheduler_if #(.IDX_W(2)) host ();
`else
  nonce_dispatch_scheduler_if host ();
`endif

  nonce_dispatch_scheduler #(.NUM_CORES(N), .LOG2_CORES(2)) dut (
    .clock(clock), .reset(reset), .work_valid(work_valid), .busy(busy),
    .job_done(job_done), .core_reset(core_reset), .core_start(core_start),
    .core_nonce_start(core_nonce_start), .core_nonce_end(core_nonce_end),
    .core_busy(core_busy), .core_found(core_found), .core_nonce(core_nonce),
    .host(host.master), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: job phase 0..5 = idle, clear, launch, wait-busy, run, done.
  int          m_phase = 0;
  bit          m_valid = 0;
  logic [31:0] m_nonce = 0;
  int          m_core  = 0;
  int          m_ptr   = 0;
  bit          m_pend [N];
  logic [31:0] m_slot [N];
  bit          m_ovf   = 0;

  always @(posedge clock) begin
    bit hs;
    bit old_pend [N];
    int old_core;
    if (reset) begin
      m_phase = 0; m_valid = 0; m_nonce = 0; m_core = 0; m_ptr = 0; m_ovf = 0;
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_slot[i] = 0; end
    end else begin
      case (m_phase)
        0: if (work_valid) m_phase = 1;
        1: m_phase = 2;
        2: m_phase = 3;
        3: if (core_busy == {N{1'b1}}) m_phase = 4;
        4: if (core_busy == '0) m_phase = 5;
        default: m_phase = 0;
      endcase
      if (work_valid) m_phase = 1;
      hs = m_valid && host.found_ready;
      old_core = m_core;
      for (int i = 0; i < N; i++) old_pend[i] = m_pend[i];
      if (hs) begin
        m_pend[m_core] = 0;
        m_ptr = (m_core + 1) % N;
        m_valid = 0;
      end else if (!m_valid) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (!m_valid && old_pend[idx]) begin
            m_valid = 1; m_nonce = m_slot[idx]; m_core = idx;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (core_found[i]) begin
          if (old_pend[i] && !(hs && old_core == i)) m_ovf = 1;
          m_pend[i] = 1;
          m_slot[i] = core_nonce[32*i +: 32];
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("busy",        busy,        32'(m_phase != 0));
      check("core_reset",  core_reset,  32'(m_phase == 1));
      check("core_start",  core_start,  32'(m_phase == 2));
      check("job_done",    job_done,    32'(m_phase == 5));
      check("found_valid", host.found_valid, 32'(m_valid));
      check("found_nonce", host.found_nonce, m_nonce);
      check("overflow",    overflow,    32'(m_ovf));
`ifdef FOUND_CORE_ID_EN
      check("found_core",  32'(host.found_core), 32'(m_core));
`endif
      if (host.found_valid && host.found_ready)
        $display("txn: core %0d nonce %h", m_core, host.found_nonce);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic find(input int core, input logic [31:0] val);
    core_found[core] = 1'b1;
    core_nonce[32*core +: 32] = val;
  endtask

  int jd, got, rise_cnt;
  int drop_cnt [N];
  logic [31:0] seen [2];

  initial begin
    host.found_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1;
    tick();
    // Reset state and constant ranges.
    for (int i = 0; i < N; i++) begin
      check("range_start", core_nonce_start[32*i +: 32], 32'(i) << 30);
      check("range_end",   core_nonce_end[32*i +: 32],   (32'(i) << 30) | 32'h3FFF_FFFF);
    end
    check("rst_busy", busy, 0);
    check("rst_valid", host.found_valid, 0);
    check("rst_overflow", overflow, 0);

    // Nominal job: busy rises at T+3, falls at T+50.
    work_valid = 1'b1;                     // cycle T
    tick(); work_valid = 1'b0;             // T+1
    check("lat_core_reset", core_reset, 1);
    check("lat_core_start_early", core_start, 0);
    tick();                                // T+2
    check("lat_core_start", core_start, 1);
    tick(); core_busy = '1;                // T+3
    for (int c = 4; c <= 50; c++) tick();  // T+50
    core_busy = '0;
    jd = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (job_done) jd++; end
    check("job_done_count", jd, 1);
    check("busy_after_job", busy, 0);

    // Cores 1 and 3 find together; drained in pointer order.
    host.found_ready = 1'b1;
    find(1, 32'h4000_0010); find(3, 32'hC000_0020);
    tick(); core_found = '0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (host.found_valid && got < 2) begin seen[got] = host.found_nonce; got++; end
    end
    check("rr_count", got, 2);
    check("rr_first", seen[0], 32'h4000_0010);
    check("rr_second", seen[1], 32'hC000_0020);
    check("rr_no_overflow", overflow, 0);

    // Core 2 held by backpressure, then overwritten.
    host.found_ready = 1'b0;
    find(2, 32'h8000_0001);
    tick(); core_found = '0;
    for (int c = 0; c < 5 && !host.found_valid; c++) tick();
    check("hold_valid", host.found_valid, 1);
    for (int c = 0; c < 5; c++) begin check("hold_stable", host.found_nonce, 32'h8000_0001); tick(); end
    find(2, 32'h8000_0002);
    tick(); core_found = '0;
    check("ovf_set", overflow, 1);
    check("ovf_still_old", host.found_nonce, 32'h8000_0001);
    host.found_ready = 1'b1; find(2, 32'h8000_0002);
    tick(); host.found_ready = 1'b0; core_found = '0;
    check("hs_drop_valid", host.found_valid, 0);
    tick();
    check("recapt_valid", host.found_valid, 1);
    check("recapt_nonce", host.found_nonce, 32'h8000_0002);
    host.found_ready = 1'b1; tick(); host.found_ready = 1'b0;

    // Abort during RUN with a pending slot.
    work_valid = 1'b1; tick(); work_valid = 1'b0;
    tick(); tick();
    core_busy = '1; find(0, 32'h0000_1234);
    tick(); core_found = '0;
    tick();
    work_valid = 1'b1; tick(); work_valid = 1'b0;
    check("abort_core_reset", core_reset, 1);
    check("abort_keep_valid", host.found_valid, 1);
    check("abort_keep_nonce", host.found_nonce, 32'h0000_1234);
    jd = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (job_done) jd++; end
    check("abort_no_done", jd, 0);
    core_busy = '0;
    for (int c = 0; c < 10; c++) begin tick(); if (job_done) jd++; end
    check("abort_second_done", jd, 1);
    host.found_ready = 1'b1; tick(); host.found_ready = 1'b0;

    // Reset while waiting for cores, with a slot pending.
    work_valid = 1'b1; tick(); work_valid = 1'b0;
    find(1, 32'h4000_ABCD); tick(); core_found = '0;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_valid", host.found_valid, 0);
    check("mrst_overflow", overflow, 0);
    check("mrst_core_reset", core_reset, 0);

    // Randomized traffic with emulated cores.
    rise_cnt = 0;
    for (int i = 0; i < N; i++) drop_cnt[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      reset      = ($urandom_range(0, 499) == 0);
      work_valid = ($urandom_range(0, 59) == 0);
      host.found_ready = ($urandom_range(0, 9) < 6);
      for (int i = 0; i < N; i++) begin
        core_found[i] = ($urandom_range(0, 7) == 0);
        core_nonce[32*i +: 32] = (32'(i) << 30) | ($urandom() & 32'h3FFF_FFFF);
      end
      if (m_phase == 1 || m_phase == 2) begin
        core_busy = '0;
        rise_cnt = (m_phase == 2) ? $urandom_range(1, 4) : 0;
      end else if (rise_cnt > 0) begin
        rise_cnt--;
        if (rise_cnt == 0) begin
          core_busy = '1;
          for (int i = 0; i < N; i++) drop_cnt[i] = $urandom_range(3, 30);
        end
      end else begin
        for (int i = 0; i < N; i++)
          if (drop_cnt[i] > 0) begin
            drop_cnt[i]--;
            if (drop_cnt[i] == 0) core_busy[i] = 1'b0;
          end
      end
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
